// File: rtl/tm_pkg.sv
// Shared types and constants for the binary-alphabet Turing machine demo.
// Latency: n/a (types only).
// Backpressure: n/a.
package tm_pkg;

  localparam int TM_DATA_W   = 6;
  localparam int TM_TAPE_LEN = 64;
  localparam int TM_WIN_HALF = 5;
  localparam int TM_WIN_W    = 2 * TM_WIN_HALF + 1;

  // Control FSM; encodings are visible on currState and must not move.
  typedef enum logic [3:0] {
    LOAD_S    = 4'd0,
    LOAD_W    = 4'd1,
    LOAD_D    = 4'd2,
    LOAD_N    = 4'd3,
    LOAD_ADDR = 4'd4,
    LOAD_TAPE = 4'd5,
    RUN       = 4'd6,
    READ      = 4'd7,
    EXEC      = 4'd8,
    HALT      = 4'd9
  } tm_state_e;

  // Head move; code 3 is unnamed and behaves like DIR_STAY.
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_STAY  = 2'd2
  } tm_dir_e;

  typedef struct packed {
    logic                 wr_bit;
    tm_dir_e              dir;
    logic [TM_DATA_W-1:0] nxt;
  } tm_entry_t;

endpackage

// File: rtl/tm_tape.sv
// Tape storage: LEN x 1-bit cells, one write port, head read port, wrapped window.
// Latency: write visible the cycle after wr_en; rd_bit and window are combinational.
// Backpressure: none, a write is accepted every cycle wr_en is high.
// Ports: clock, reset (async active-low, clears tape), wr_en/wr_addr/wr_bit,
//        head (read/window centre), rd_bit (cell under head), window (bit i = cell head-HALF+i).
module tm_tape
  import tm_pkg::*;
#(
  parameter int ADDR_W = TM_DATA_W,
  parameter int LEN    = TM_TAPE_LEN
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                wr_bit,
  input  logic [ADDR_W-1:0]   head,
  output logic                rd_bit,
  output logic [TM_WIN_W-1:0] window
);

  logic [LEN-1:0] cells;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cells <= '0;
    end else if (wr_en) begin
      cells[wr_addr] <= wr_bit;
    end
  end

  assign rd_bit = cells[head];

  // Address arithmetic is ADDR_W bits wide, so the window wraps modulo LEN.
  always_comb begin
    window = '0;
    for (int i = 0; i < TM_WIN_W; i++) begin
      window[i] = cells[ADDR_W'(head + ADDR_W'(i) - ADDR_W'(TM_WIN_HALF))];
    end
  end

endmodule

// File: rtl/turing_machine_core.sv
// Button-driven single-tape binary Turing machine: program load, tape load, step on Next.
// Latency: load commits 2 cycles after a button rises; a step shows on outputs 4 cycles after Next rises.
// Backpressure: none; button events arriving in states that do not use them are dropped.
// Ports: clock, reset (async active-low), input_data, Next/Done (level buttons),
//        display_out (11-cell window, bit 5 = head), Compute_done, currState,
//        tape_reg_out, data_reg_out, direction_out, next_state_out, tape_addr_out.
// Build option: define TM_AUTORUN_EN to also self-step every 4 cycles while running.
module turing_machine_core
  import tm_pkg::*;
#(
  parameter int DATA_W   = TM_DATA_W,
  parameter int TAPE_LEN = TM_TAPE_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_data,
  input  logic              Next,
  input  logic              Done,
  output logic [10:0]       display_out,
  output logic              Compute_done,
  output logic [3:0]        currState,
  output logic              tape_reg_out,
  output logic              data_reg_out,
  output logic [1:0]        direction_out,
  output logic [DATA_W-1:0] next_state_out,
  output logic [DATA_W-1:0] tape_addr_out
);

  localparam int TBL_N = 2 ** DATA_W;

  // ---------------- button edge detection ----------------
  logic armed_q;
  logic next_q, next_prev_q, done_q, done_prev_q;
  logic next_ev, done_ev, step_go;

  // On the first cycle after reset the "previous" stage is loaded from the
  // raw button, so a button already held through reset never looks like a rise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_q     <= 1'b0;
      next_q      <= 1'b0;
      next_prev_q <= 1'b0;
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      armed_q     <= 1'b1;
      next_q      <= Next;
      done_q      <= Done;
      next_prev_q <= armed_q ? next_q : Next;
      done_prev_q <= armed_q ? done_q : Done;
    end
  end

  assign next_ev = next_q & ~next_prev_q;
  assign done_ev = done_q & ~done_prev_q;

  // ---------------- state ----------------
  tm_state_e         state_q, state_d;
  logic [DATA_W-1:0] s_q;
  logic [DATA_W-1:0] k_q;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] ptr_q;
  logic [DATA_W-1:0] mstate_q;
  logic              tape_reg_q;
  logic              data_reg_q;
  tm_dir_e           dir_q;
  tm_entry_t         tbl_q [TBL_N];
  logic [TBL_N-1:0]  tbl_vld_q;

  logic              tape_rd;
  logic [10:0]       tape_win;
  logic              tape_we;
  logic [DATA_W-1:0] tape_waddr;
  logic              tape_wbit;

`ifdef TM_AUTORUN_EN
  // Free-runs through RUN/READ/EXEC so auto-steps start every 4 cycles.
  logic [1:0] auto_cnt_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      auto_cnt_q <= '0;
    end else if (state_q == RUN || state_q == READ || state_q == EXEC) begin
      auto_cnt_q <= auto_cnt_q + 2'd1;
    end else begin
      auto_cnt_q <= '0;
    end
  end
  assign step_go = next_ev | (auto_cnt_q == 2'd3);
`else
  assign step_go = next_ev;
`endif

  // ---------------- table lookup ----------------
  logic [DATA_W-1:0] tbl_idx;
  tm_entry_t         entry;
  logic [DATA_W-1:0] head_moved;

  assign tbl_idx = {mstate_q[DATA_W-2:0], tape_reg_q};

  always_comb begin
    entry = '{wr_bit: 1'b0, dir: DIR_STAY, nxt: s_q};
    if (tbl_vld_q[tbl_idx]) begin
      entry = tbl_q[tbl_idx];
    end
  end

  always_comb begin
    head_moved = head_q;
    if (entry.dir == DIR_LEFT) begin
      head_moved = head_q - 1'b1;
    end else if (entry.dir == DIR_RIGHT) begin
      head_moved = head_q + 1'b1;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD_S;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_S:    if (done_ev) state_d = LOAD_ADDR; else if (next_ev) state_d = LOAD_W;
      LOAD_W:    if (done_ev) state_d = LOAD_ADDR; else if (next_ev) state_d = LOAD_D;
      LOAD_D:    if (done_ev) state_d = LOAD_ADDR; else if (next_ev) state_d = LOAD_N;
      LOAD_N:    if (done_ev) state_d = LOAD_ADDR; else if (next_ev) state_d = LOAD_W;
      LOAD_ADDR: if (done_ev) state_d = RUN;       else if (next_ev) state_d = LOAD_TAPE;
      LOAD_TAPE: if (done_ev) state_d = RUN;
      RUN:       if (mstate_q == s_q) state_d = HALT; else if (step_go) state_d = READ;
      READ:      state_d = EXEC;
      EXEC:      state_d = RUN;
      HALT:      state_d = HALT;
      default:   state_d = LOAD_S;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_q        <= '0;
      k_q        <= '0;
      head_q     <= '0;
      ptr_q      <= '0;
      mstate_q   <= '0;
      tape_reg_q <= 1'b0;
      data_reg_q <= 1'b0;
      dir_q      <= DIR_LEFT;
      tbl_vld_q  <= '0;
      for (int i = 0; i < TBL_N; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      case (state_q)
        LOAD_S: if (!done_ev && next_ev) begin
          s_q <= input_data;
          k_q <= '0;
        end
        LOAD_W: if (!done_ev && next_ev) begin
          tbl_q[k_q].wr_bit <= input_data[0];
        end
        LOAD_D: if (!done_ev && next_ev) begin
          tbl_q[k_q].dir <= tm_dir_e'(input_data[1:0]);
        end
        // An entry only becomes live once its next-state field is in.
        LOAD_N: if (!done_ev && next_ev) begin
          tbl_q[k_q].nxt   <= input_data;
          tbl_vld_q[k_q]   <= 1'b1;
          k_q              <= k_q + 1'b1;
        end
        LOAD_ADDR: begin
          if (done_ev) begin
            head_q   <= '0;
            mstate_q <= '0;
          end else if (next_ev) begin
            head_q <= input_data;
            ptr_q  <= input_data;
          end
        end
        LOAD_TAPE: begin
          if (done_ev) begin
            mstate_q <= '0;
          end else if (next_ev) begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        READ: tape_reg_q <= tape_rd;
        EXEC: begin
          data_reg_q <= entry.wr_bit;
          dir_q      <= entry.dir;
          mstate_q   <= entry.nxt;
          head_q     <= head_moved;
        end
        default: ;
      endcase
    end
  end

  // ---------------- tape ----------------
  assign tape_we    = (state_q == EXEC) || (state_q == LOAD_TAPE && next_ev && !done_ev);
  assign tape_waddr = (state_q == EXEC) ? head_q : ptr_q;
  assign tape_wbit  = (state_q == EXEC) ? entry.wr_bit : input_data[0];

  tm_tape #(
    .ADDR_W(DATA_W),
    .LEN   (TAPE_LEN)
  ) u_tape (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (tape_we),
    .wr_addr(tape_waddr),
    .wr_bit (tape_wbit),
    .head   (head_q),
    .rd_bit (tape_rd),
    .window (tape_win)
  );

  // ---------------- outputs ----------------
  assign display_out    = tape_win;
  assign Compute_done   = (state_q == HALT);
  assign currState      = state_q;
  assign tape_reg_out   = tape_reg_q;
  assign data_reg_out   = data_reg_q;
  assign direction_out  = dir_q;
  assign next_state_out = mstate_q;
  assign tape_addr_out  = head_q;

endmodule

// File: tb/tb_turing_machine_core.sv
// Directed bench for turing_machine_core with hand-computed expectations.
module tb_turing_machine_core;

  logic        clock;
  logic        reset;
  logic [5:0]  input_data;
  logic        Next;
  logic        Done;
  logic [10:0] display_out;
  logic        Compute_done;
  logic [3:0]  currState;
  logic        tape_reg_out;
  logic        data_reg_out;
  logic [1:0]  direction_out;
  logic [5:0]  next_state_out;
  logic [5:0]  tape_addr_out;

  int checks   = 0;
  int failures = 0;

  turing_machine_core dut (
    .clock         (clock),
    .reset         (reset),
    .input_data    (input_data),
    .Next          (Next),
    .Done          (Done),
    .display_out   (display_out),
    .Compute_done  (Compute_done),
    .currState     (currState),
    .tape_reg_out  (tape_reg_out),
    .data_reg_out  (data_reg_out),
    .direction_out (direction_out),
    .next_state_out(next_state_out),
    .tape_addr_out (tape_addr_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One button press: held for several cycles (still a single event), then released.
  task automatic press(input bit is_done, input logic [5:0] data);
    @(negedge clock);
    input_data = data;
    if (is_done) Done = 1'b1; else Next = 1'b1;
    repeat (6) @(negedge clock);
    Next = 1'b0;
    Done = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset      = 1'b0;
    input_data = '0;
    Done       = 1'b0;
    Next       = 1'b1;   // held through reset: must not produce an event

    // ---- reset with Next held ----
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("rst_state", currState, 0);
    check("rst_disp", display_out, 0);
    check("rst_done", Compute_done, 0);
    check("rst_head", tape_addr_out, 0);
    check("rst_misc", {tape_reg_out, data_reg_out, direction_out, next_state_out}, 0);
    Next = 1'b0;
    repeat (2) @(negedge clock);

    // ---- program: S=1, (0,0)=w1/R/0, (0,1)=w1/R/1 ----
    press(0, 6'd1);
    check("load_s_state", currState, 1);
    press(0, 6'd1); press(0, 6'd1); press(0, 6'd0);
    check("after_entry0", currState, 1);
    press(0, 6'd1); press(0, 6'd1); press(0, 6'd1);
    press(1, 6'd0);
    check("prog_done", currState, 4);
    press(0, 6'd10);
    check("load_addr", tape_addr_out, 10);
    check("load_tape_st", currState, 5);
    press(0, 6'd0); press(0, 6'd0); press(0, 6'd1);
    press(1, 6'd0);
    check("run_state", currState, 6);
    check("run_disp", display_out, 11'h080);
    check("run_head", tape_addr_out, 10);

    press(0, 6'd0);
    check("step1_disp", display_out, 11'h050);
    check("step1_head", tape_addr_out, 11);
    check("step1_done", Compute_done, 0);
    press(0, 6'd0);
    check("step2_disp", display_out, 11'h038);
    check("step2_head", tape_addr_out, 12);
    press(0, 6'd0);
    check("step3_disp", display_out, 11'h01C);
    check("step3_head", tape_addr_out, 13);
    check("step3_done", Compute_done, 1);
    check("step3_state", currState, 9);
    check("step3_dbg", {tape_reg_out, data_reg_out, direction_out, next_state_out},
          {1'b1, 1'b1, 2'd1, 6'd1});

    // ---- halt ignores buttons ----
    press(0, 6'd0); press(0, 6'd0); press(0, 6'd0); press(1, 6'd0);
    check("halt_disp", display_out, 11'h01C);
    check("halt_done", Compute_done, 1);
    check("halt_head", tape_addr_out, 13);

    // ---- wrap: tape at 63 ----
    do_reset();
    check("rst2_state", currState, 0);
    press(0, 6'd1);
    press(0, 6'd1); press(0, 6'd1); press(0, 6'd1);
    press(0, 6'd1); press(0, 6'd1); press(0, 6'd1);
    press(1, 6'd0);
    press(0, 6'd63);
    press(0, 6'd1); press(0, 6'd1);
    press(1, 6'd0);
    check("wrap_disp0", display_out, 11'h060);
    check("wrap_head0", tape_addr_out, 63);
    press(0, 6'd0);
    check("wrap_head1", tape_addr_out, 0);
    check("wrap_disp1", display_out, 11'h030);
    check("wrap_done", Compute_done, 1);

    // ---- reset mid-computation; S=3, (0,0)=w1/R/0, Done in LOAD_ADDR -> head 0 ----
    do_reset();
    press(0, 6'd3);
    press(0, 6'd1); press(0, 6'd1); press(0, 6'd0);
    press(1, 6'd0);
    press(0, 6'd20);
    press(1, 6'd0);     // from LOAD_TAPE? no: first Done left program load, this one is tape-load Done
    check("mid_head_load", tape_addr_out, 20);
    do_reset();
    press(0, 6'd3);
    press(0, 6'd1); press(0, 6'd1); press(0, 6'd0);
    press(1, 6'd0);
    press(1, 6'd0);     // Done straight from LOAD_ADDR
    check("addr_done_head", tape_addr_out, 0);
    check("addr_done_st", currState, 6);
    press(0, 6'd0);
    check("mid_step_disp", display_out, 11'h010);
    check("mid_step_head", tape_addr_out, 1);
    @(negedge clock);
    Next = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_exec_state", currState, 8);
    reset = 1'b0;
    #1;
    check("mid_rst_state", currState, 0);
    check("mid_rst_done", Compute_done, 0);
    check("mid_rst_disp", display_out, 0);
    check("mid_rst_head", tape_addr_out, 0);
    Next = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // ---- unloaded entries: S=2, empty table -> write 0 / stay / next=S ----
    press(0, 6'd2);
    press(1, 6'd0);
    press(1, 6'd0);
    check("empty_disp", display_out, 0);
    press(0, 6'd0);
    check("dflt_dir", direction_out, 2);
    check("dflt_next", next_state_out, 2);
    check("dflt_head", tape_addr_out, 0);
    check("dflt_done", Compute_done, 1);
    check("dflt_disp", display_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
